// File: rtl/fifo_reader_pkg.sv
// Shared types and default sizes for the FIFO read-side controller.
package fifo_reader_pkg;

  localparam int unsigned FifoWidthDefault = 16;
  localparam int unsigned CntWidthDefault  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } state_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer: entry 0 is the head presented downstream, entry 1 the tail.
module fifo_reader_skid #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic [1:0]       occ_q, occ_d;

  // Next-state for entries and occupancy; pop is only ever raised with occ > 0.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case ({wr, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          e0_d = wdata;
        end else begin
          e1_d = wdata;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        // Capture and pop together: occupancy is unchanged, the queue shifts.
        if (occ_q == 2'd1) begin
          e0_d = wdata;
        end else begin
          e0_d = e1_q;
          e1_d = wdata;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = e0_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: drains the synchronous FIFO into a valid/ready stream,
// hiding the FIFO's one-cycle read latency behind a 2-entry skid buffer.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FifoWidthDefault,
  parameter int unsigned CNT_WIDTH  = CntWidthDefault
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  underflow_count,
  output logic                  proto_err
);

  state_e                 state_q, state_d;
  logic                   pend_q;
  logic                   proto_err_q, proto_err_d;
  logic [CNT_WIDTH-1:0]   rd_count_q, rd_count_d;
  logic [CNT_WIDTH-1:0]   uf_count_q, uf_count_d;
  logic [1:0]             occ;
  logic                   pop;
  logic [2:0]             fill_after;

  fifo_reader_skid #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .wr    (pend_q),
    .wdata (fifo_data_out),
    .pop   (pop),
    .occ   (occ),
    .head  (m_data)
  );

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign busy    = (state_q != StIdle);

  // Words held after this edge if nothing new is read; a read is safe only if this is <= 1.
  assign fill_after = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};

  // Read strobe; never raised while the FIFO reports empty.
  always_comb begin
    fifo_rd_en = (state_q == StRun) && !fifo_empty && (fill_after <= 3'd1);
  end

  // FSM next state: STOP lingers until the in-flight word and buffer have drained.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en) state_d = StRun;
      StRun:  if (!en) state_d = StStop;
      StStop: begin
        if (en) begin
          state_d = StRun;
        end else if (!pend_q && (occ == 2'd0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating statistics and the sticky protocol-error flag.
  always_comb begin
    rd_count_d  = rd_count_q;
    uf_count_d  = uf_count_q;
    proto_err_d = proto_err_q;
    if (pend_q && (rd_count_q != '1)) begin
      rd_count_d = rd_count_q + 1'b1;
    end
    if (fifo_underflow && (uf_count_q != '1)) begin
      uf_count_d = uf_count_q + 1'b1;
    end
    if (fifo_underflow && pend_q) begin
      proto_err_d = 1'b1;
    end
  end

  // State, in-flight marker and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      proto_err_q <= 1'b0;
      rd_count_q  <= '0;
      uf_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= fifo_rd_en;
      proto_err_q <= proto_err_d;
      rd_count_q  <= rd_count_d;
      uf_count_q  <= uf_count_d;
    end
  end

  assign rd_count        = rd_count_q;
  assign underflow_count = uf_count_q;
  assign proto_err       = proto_err_q;

endmodule
